// File: rtl/packet_rx_queue.sv
// Receive-side Ethernet frame filter feeding a circular queue of fixed-size RAM slots.
// Optional FCS verification is built in when PACKET_RX_QUEUE_FCS_CHECK_EN is defined.
module packet_rx_queue #(
    parameter int ADDR_W = 6,
    parameter int SLOT_W = 1,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               data,
    input  logic [1:0]               ctl,
    input  logic [47:0]              mac_addr,
    input  logic                     promisc,
    output logic [SLOT_W+ADDR_W-1:0] eth_rx_addr,
    output logic [7:0]               eth_rx_wdata,
    output logic                     eth_rx_we,
    output logic                     eth_rx_ready,
    output logic [SLOT_W-1:0]        eth_rx_slot,
    output logic [ADDR_W:0]          eth_rx_len,
    input  logic                     eth_rx_read,
    output logic [DROP_W-1:0]        drop_count
);
    localparam int NSLOT = 1 << SLOT_W;
    localparam logic [SLOT_W:0] FULL = {1'b1, {SLOT_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, PREAMBLE, DEST, PAYLOAD, DRAIN, IGNORE} state_t;

    state_t              state_reg, state_next;
    logic [2:0]          dest_cnt_reg, dest_cnt_next;
    logic                ucast_reg, ucast_next, bcast_reg, bcast_next;
    logic                bad_reg, bad_next;
    logic [ADDR_W-1:0]   offset_reg, offset_next;
    logic [ADDR_W:0]     len_reg, len_next;
    logic [SLOT_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [SLOT_W:0]     count_reg;
    logic [DROP_W-1:0]   drop_reg;
    logic                hold_reg;
    logic                commit, drop, we, pop, frame_ok, fcs_ok;
    logic                good, eof, u_ok, b_ok;
    logic [7:0]          mac_byte [8];
    logic [ADDR_W:0]     len_arr [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mac
            if (gi < 6) begin : g_real
                assign mac_byte[gi] = mac_addr[47-8*gi -: 8];
            end else begin : g_pad
                assign mac_byte[gi] = 8'h00;
            end
        end

        // Per-slot committed length; only the slot at wr_ptr is ever written.
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            logic [ADDR_W:0] len_q;
            always_ff @(posedge clk) begin
                if (reset)
                    len_q <= '0;
                else if (commit && wr_ptr_reg == SLOT_W'(gi))
                    len_q <= len_reg;
            end
            assign len_arr[gi] = len_q;
        end
    endgenerate

`ifdef PACKET_RX_QUEUE_FCS_CHECK_EN
    logic [31:0] crc_reg;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            crc_reg <= '1;
        else if (state_reg == PREAMBLE && state_next == DEST)
            crc_reg <= '1;
        else if (ctl[1] && (state_reg == DEST || state_reg == PAYLOAD || state_reg == DRAIN))
            crc_reg <= crc_byte(crc_reg, data);
    end

    // Reflected-register residue; equals C704DD7B in normal bit order.
    assign fcs_ok = (crc_reg == 32'hDEBB20E3);
`else
    assign fcs_ok = 1'b1;
`endif

    assign good     = (ctl == 2'b11);
    assign eof      = ~ctl[1];
    assign u_ok     = ucast_reg && (data == mac_byte[dest_cnt_reg]);
    assign b_ok     = bcast_reg && (data == 8'hFF);
    assign frame_ok = ~bad_reg && (len_reg != '0) && fcs_ok;
    assign pop      = eth_rx_read && eth_rx_ready;

    always_comb begin
        state_next    = state_reg;
        dest_cnt_next = dest_cnt_reg;
        ucast_next    = ucast_reg;
        bcast_next    = bcast_reg;
        bad_next      = bad_reg;
        offset_next   = offset_reg;
        len_next      = len_reg;
        commit        = 1'b0;
        drop          = 1'b0;
        we            = 1'b0;
        if (ctl == 2'b10 && (state_reg == DEST || state_reg == PAYLOAD || state_reg == DRAIN))
            bad_next = 1'b1;
        case (state_reg)
            IDLE: if (good && !hold_reg) state_next = PREAMBLE;
            PREAMBLE: begin
                if (eof)
                    state_next = IDLE;
                else if (good && data == 8'hD5) begin
                    state_next    = DEST;
                    dest_cnt_next = 3'd0;
                    ucast_next    = 1'b1;
                    bcast_next    = 1'b1;
                    bad_next      = 1'b0;
                end
            end
            DEST: begin
                if (eof)
                    state_next = IDLE;
                else begin
                    ucast_next    = u_ok;
                    bcast_next    = b_ok;
                    dest_cnt_next = dest_cnt_reg + 3'd1;
                    if (dest_cnt_reg == 3'd5) begin
                        // A free slot here is implicitly reserved: wr_ptr is not committed yet.
                        if (!(u_ok || b_ok || promisc))
                            state_next = IGNORE;
                        else if (count_reg != FULL) begin
                            state_next  = PAYLOAD;
                            offset_next = '0;
                            len_next    = '0;
                        end else begin
                            state_next = IGNORE;
                            drop       = 1'b1;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (eof) begin
                    state_next = IDLE;
                    commit     = frame_ok;
                end else begin
                    we          = good;
                    offset_next = offset_reg + 1'b1;
                    len_next    = len_reg + 1'b1;
                    if (offset_reg == '1) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (eof) begin
                    state_next = IDLE;
                    commit     = frame_ok;
                end
            end
            IGNORE:  if (eof) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            dest_cnt_reg <= '0;
            ucast_reg    <= 1'b0;
            bcast_reg    <= 1'b0;
            bad_reg      <= 1'b0;
            offset_reg   <= '0;
            len_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_reg     <= '0;
            hold_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            dest_cnt_reg <= dest_cnt_next;
            ucast_reg    <= ucast_next;
            bcast_reg    <= bcast_next;
            bad_reg      <= bad_next;
            offset_reg   <= offset_next;
            len_reg      <= len_next;
            // Blocks a restart inside a frame that was cut by reset.
            hold_reg     <= hold_reg && good;
            if (commit) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (commit && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !commit)
                count_reg <= count_reg - 1'b1;
            if (drop && drop_reg != '1) drop_reg <= drop_reg + 1'b1;
        end
    end

    assign eth_rx_addr  = {wr_ptr_reg, offset_reg};
    assign eth_rx_wdata = data;
    assign eth_rx_we    = we;
    assign eth_rx_ready = (count_reg != '0);
    assign eth_rx_slot  = rd_ptr_reg;
    assign eth_rx_len   = eth_rx_ready ? len_arr[rd_ptr_reg] : '0;
    assign drop_count   = drop_reg;
endmodule

// File: tb/tb_packet_rx_queue.sv
// Directed bench for packet_rx_queue: filtering, slot queue, drops, errors, mid-frame reset.
module tb_packet_rx_queue;
    localparam int AW = 6;
    localparam int SW = 1;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        data = 8'h00;
    logic [1:0]        ctl = 2'b00;
    logic [47:0]       mac_addr = 48'h02_00_00_00_00_01;
    logic              promisc = 1'b0;
    logic [SW+AW-1:0]  eth_rx_addr;
    logic [7:0]        eth_rx_wdata;
    logic              eth_rx_we;
    logic              eth_rx_ready;
    logic [SW-1:0]     eth_rx_slot;
    logic [AW:0]       eth_rx_len;
    logic              eth_rx_read = 1'b0;
    logic [DW-1:0]     drop_count;

    int checks = 0;
    int failures = 0;
    int we_seen = 0;

    packet_rx_queue #(.ADDR_W(AW), .SLOT_W(SW), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .data(data), .ctl(ctl), .mac_addr(mac_addr),
        .promisc(promisc), .eth_rx_addr(eth_rx_addr), .eth_rx_wdata(eth_rx_wdata),
        .eth_rx_we(eth_rx_we), .eth_rx_ready(eth_rx_ready), .eth_rx_slot(eth_rx_slot),
        .eth_rx_len(eth_rx_len), .eth_rx_read(eth_rx_read), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] c, input logic rd);
        @(negedge clk);
        data = d;
        ctl = c;
        eth_rx_read = rd;
        #1;
        if (eth_rx_we) we_seen++;
    endtask

    task automatic send_frame(input logic [47:0] dest, input int n, input int err_at,
                              input logic [SW-1:0] exp_slot, input logic rd_at_eof);
        logic [7:0]    b;
        logic [AW-1:0] off;
        for (int k = 0; k < 7; k++) drive(8'h55, 2'b11, 1'b0);
        drive(8'hD5, 2'b11, 1'b0);
        for (int k = 0; k < 6; k++) drive(dest[47-8*k -: 8], 2'b11, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = i[7:0] ^ 8'h3C;
            off = i[AW-1:0];
            drive(b, (i == err_at) ? 2'b10 : 2'b11, 1'b0);
            if (eth_rx_we) begin
                chk("wr_addr", 64'(eth_rx_addr), 64'({exp_slot, off}));
                chk("wr_data", 64'(eth_rx_wdata), 64'(b));
            end
        end
        drive(8'h00, 2'b00, rd_at_eof);
        drive(8'h00, 2'b00, 1'b0);
        drive(8'h00, 2'b00, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) drive(8'h00, 2'b00, 1'b0);
        reset = 1'b0;
        drive(8'h00, 2'b00, 1'b0);
        drive(8'h00, 2'b00, 1'b0);
        chk("rst_ready", 64'(eth_rx_ready), 64'd0);
        chk("rst_we", 64'(eth_rx_we), 64'd0);
        chk("rst_addr", 64'(eth_rx_addr), 64'd0);
        chk("rst_len", 64'(eth_rx_len), 64'd0);
        chk("rst_slot", 64'(eth_rx_slot), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        // Unicast 60 bytes into slot 0
        we_seen = 0;
        send_frame(48'h02_00_00_00_00_01, 60, -1, 1'b0, 1'b0);
        chk("uc_we_cycles", 64'(we_seen), 64'd60);
        chk("uc_ready", 64'(eth_rx_ready), 64'd1);
        chk("uc_len", 64'(eth_rx_len), 64'd60);
        chk("uc_slot", 64'(eth_rx_slot), 64'd0);

        // Broadcast 100 bytes into slot 1: truncated to 64
        we_seen = 0;
        send_frame(48'hFF_FF_FF_FF_FF_FF, 100, -1, 1'b1, 1'b0);
        chk("bc_we_cycles", 64'(we_seen), 64'd64);
        chk("bc_oldest_len", 64'(eth_rx_len), 64'd60);

        // Partial-FF destination, not promiscuous: ignored
        we_seen = 0;
        send_frame(48'hFF_00_00_00_00_01, 20, -1, 1'b0, 1'b0);
        chk("ign_we_cycles", 64'(we_seen), 64'd0);
        chk("ign_drop", 64'(drop_count), 64'd0);

        // Queue full: third good frame dropped
        we_seen = 0;
        send_frame(48'h02_00_00_00_00_01, 10, -1, 1'b0, 1'b0);
        chk("full_we_cycles", 64'(we_seen), 64'd0);
        chk("full_drop", 64'(drop_count), 64'd1);
        chk("full_slot", 64'(eth_rx_slot), 64'd0);

        drive(8'h00, 2'b00, 1'b1);
        drive(8'h00, 2'b00, 1'b0);
        chk("rd1_slot", 64'(eth_rx_slot), 64'd1);
        chk("rd1_ready", 64'(eth_rx_ready), 64'd1);
        chk("rd1_len", 64'(eth_rx_len), 64'd64);
        drive(8'h00, 2'b00, 1'b1);
        drive(8'h00, 2'b00, 1'b0);
        chk("rd2_ready", 64'(eth_rx_ready), 64'd0);
        chk("rd2_len", 64'(eth_rx_len), 64'd0);
        drive(8'h00, 2'b00, 1'b1);
        drive(8'h00, 2'b00, 1'b0);
        chk("rd_empty_slot", 64'(eth_rx_slot), 64'd0);

        // Commit and read in the same cycle with one entry queued
        send_frame(48'h02_00_00_00_00_01, 20, -1, 1'b0, 1'b0);
        chk("c_ready", 64'(eth_rx_ready), 64'd1);
        chk("c_len", 64'(eth_rx_len), 64'd20);
        send_frame(48'h02_00_00_00_00_01, 30, -1, 1'b1, 1'b1);
        chk("cr_ready", 64'(eth_rx_ready), 64'd1);
        chk("cr_slot", 64'(eth_rx_slot), 64'd1);
        chk("cr_len", 64'(eth_rx_len), 64'd30);
        drive(8'h00, 2'b00, 1'b1);
        drive(8'h00, 2'b00, 1'b0);
        chk("cr_drain_ready", 64'(eth_rx_ready), 64'd0);

        // Error byte mid-payload: written around, never committed
        we_seen = 0;
        send_frame(48'h02_00_00_00_00_01, 25, 10, 1'b0, 1'b0);
        chk("err_we_cycles", 64'(we_seen), 64'd24);
        chk("err_ready", 64'(eth_rx_ready), 64'd0);

        // Promiscuous accept of a foreign address
        promisc = 1'b1;
        send_frame(48'h12_34_56_78_9A_BC, 5, -1, 1'b0, 1'b0);
        promisc = 1'b0;
        chk("pr_ready", 64'(eth_rx_ready), 64'd1);
        chk("pr_slot", 64'(eth_rx_slot), 64'd0);
        chk("pr_len", 64'(eth_rx_len), 64'd5);

        // Reset mid-frame, then a well-formed-looking tail must be ignored
        for (int k = 0; k < 7; k++) drive(8'h55, 2'b11, 1'b0);
        drive(8'hD5, 2'b11, 1'b0);
        for (int k = 0; k < 6; k++) drive(mac_addr[47-8*k -: 8], 2'b11, 1'b0);
        for (int i = 0; i < 10; i++) drive(8'hA0 + i[7:0], 2'b11, 1'b0);
        reset = 1'b1;
        drive(8'h55, 2'b11, 1'b0);
        reset = 1'b0;
        we_seen = 0;
        drive(8'h55, 2'b11, 1'b0);
        chk("mr_ready", 64'(eth_rx_ready), 64'd0);
        chk("mr_len", 64'(eth_rx_len), 64'd0);
        drive(8'hD5, 2'b11, 1'b0);
        for (int k = 0; k < 6; k++) drive(mac_addr[47-8*k -: 8], 2'b11, 1'b0);
        for (int i = 0; i < 10; i++) drive(8'h10 + i[7:0], 2'b11, 1'b0);
        drive(8'h00, 2'b00, 1'b0);
        drive(8'h00, 2'b00, 1'b0);
        chk("mr_tail_we", 64'(we_seen), 64'd0);
        chk("mr_tail_ready", 64'(eth_rx_ready), 64'd0);

        we_seen = 0;
        send_frame(48'h02_00_00_00_00_01, 8, -1, 1'b0, 1'b0);
        chk("post_we_cycles", 64'(we_seen), 64'd8);
        chk("post_ready", 64'(eth_rx_ready), 64'd1);
        chk("post_len", 64'(eth_rx_len), 64'd8);
        chk("post_slot", 64'(eth_rx_slot), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/packet_rx_queue.md
PACKET_RX_QUEUE -- requirements
Module: packet_rx_queue

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 6, giving log2 of bytes stored per slot (DEPTH = 2^ADDR_W).
REQ-002 The block SHALL have parameter SLOT_W, default 1, giving log2 of the slot count (NSLOT = 2^SLOT_W).
REQ-003 The block SHALL have parameter DROP_W, default 16, giving the width of the drop counter.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk, input, 1, receive byte clock; reset, input, 1, synchronous active-high reset.
REQ-005 Remaining ports SHALL be:
- data, in, 8, receive byte.
- ctl, in, 2: 11 valid; 10 valid with error; 0x end of frame.
- mac_addr, in, 48: station address.
- promisc, in, 1: accept every destination.
- eth_rx_addr, out, SLOT_W+ADDR_W: {slot, byte offset}.
- eth_rx_wdata, out, 8: data, combinational.
- eth_rx_we, out, 1: RAM write enable.
- eth_rx_ready, out, 1: at least one committed slot.
- eth_rx_slot, out, SLOT_W: oldest committed slot.
- eth_rx_len, out, ADDR_W+1: bytes stored in eth_rx_slot.
- eth_rx_read, in, 1: one-cycle pulse that frees the oldest slot.
- drop_count, out, DROP_W: frames dropped for lack of a free slot.

Function
REQ-006 The state machine SHALL use states IDLE, PREAMBLE, DEST, PAYLOAD, DRAIN and IGNORE.
REQ-007 Transitions before PAYLOAD:
- IDLE to PREAMBLE on ctl==11.
- PREAMBLE to DEST on data==8'hD5.
- DEST compares 6 bytes, MSB first, using a 3-bit counter.
REQ-008 Address filtering:
- Accept when all 6 bytes equal mac_addr, or all 6 equal FF (whole-address broadcast; no per-byte FF wildcard), or promisc==1.
- Reject in DEST goes to IGNORE.
REQ-009 On acceptance with a free slot, the machine SHALL enter PAYLOAD with offset 0. If no slot is free, it SHALL enter IGNORE and increment drop_count, saturating at all-ones.
REQ-010 PAYLOAD:
- eth_rx_we=1 while ctl==11.
- Offset increments each byte.
- When offset DEPTH-1 is written, go to DRAIN with we=0.
- Byte latency from data to eth_rx_wdata is 0 cycles; eth_rx_addr is registered, aligned with data.
REQ-011 DRAIN SHALL write nothing and SHALL track frame end and errors only.
REQ-012 Any ctl==10 byte in DEST, PAYLOAD or DRAIN SHALL mark the frame bad.
REQ-013 End of frame (ctl[1]==0) in PAYLOAD or DRAIN:
- Commit the slot (store len, advance write slot) only if the frame is not bad and len is at least 1.
- Then go to IDLE.
REQ-014 End of frame in PREAMBLE, DEST or IGNORE SHALL go to IDLE with no commit.
REQ-015 eth_rx_len SHALL equal min(bytes after destination MAC, DEPTH), including FCS bytes.
REQ-016 The queue SHALL be circular:
- eth_rx_ready = (count != 0).
- eth_rx_read with count==0 is ignored.
- A read pops the oldest slot and advances eth_rx_slot in the next cycle.
REQ-017 A commit and a read in the same cycle SHALL leave count unchanged and advance both pointers. A read SHALL never free the slot currently being written.
REQ-018 The write slot SHALL be reserved at acceptance, so a concurrent read cannot alias it.

Reset
REQ-019 Reset SHALL set:
- state=IDLE, eth_rx_we=0, eth_rx_addr=0.
- Read/write pointers and count = 0, eth_rx_ready=0.
- eth_rx_len=0, drop_count=0.
REQ-020 Reset mid-frame SHALL discard the partial frame and all queued slots. The remainder of that frame SHALL be ignored until ctl leaves 11.

Configuration
REQ-021 Macro PACKET_RX_QUEUE_FCS_CHECK_EN behaviour:
- When defined: a CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) SHALL run over destination MAC through FCS. A frame SHALL commit only if the residue equals C704DD7B; otherwise it is treated as bad.
- When undefined: no CRC logic; commit depends only on REQ-013.

Verification
REQ-022 Unicast 60-byte payload to mac_addr=02:00:00:00:00:01, ADDR_W=6 -> we high 60 cycles, addr 0..59 in slot 0, then ready=1, len=60, slot=0.
REQ-023 100-byte frame to FF:FF:FF:FF:FF:FF -> 64 bytes written, DRAIN until end, len=64. Destination FF:00:00:00:00:01 with promisc=0 -> IGNORE, nothing written.
REQ-024 SLOT_W=1: three good frames with no reads -> first two commit, third dropped, drop_count=1; one read pulse -> slot advances to 1, ready stays 1.
REQ-025 Commit and eth_rx_read in the same cycle with count=1 -> count stays 1, slot pointer advances, ready stays 1.
REQ-026 One byte with ctl=10 mid-payload -> no commit. With FCS_CHECK_EN: corrupted FCS -> no commit; correct FCS -> commit.
